// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
//   Two-source round-robin arbiter for a shared GMII transmit port. One
//   source is granted per frame and its byte stream is forwarded through a
//   single register stage. A minimum inter-frame gap is enforced after every
//   frame. A granted source that never raises txen loses its grant after
//   START_TIMEOUT cycles.
//
// Ports
//   GMII_GTXCLK             transmit clock, rising edge
//   rst_n                   synchronous active-low reset
//   req0/req1               level requests, held until the frame is done
//   gnt0/gnt1               registered one-hot (or zero) grant
//   txd*/txen*/txer*        per-source GMII transmit signals
//   GMII_TXD/TXEN/TXER      registered shared output
//   frame_cnt0/frame_cnt1   completed frames per source (wrapping)
//   timeout_cnt             start-timeout events (saturating)
module gmii_tx_arbiter #(
    parameter int IPG_CYCLES    = 12,
    parameter int START_TIMEOUT = 64
) (
    input  logic        GMII_GTXCLK,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic [7:0]  txd0,
    input  logic [7:0]  txd1,
    input  logic        txen0,
    input  logic        txen1,
    input  logic        txer0,
    input  logic        txer1,
    output logic [7:0]  GMII_TXD,
    output logic        GMII_TXEN,
    output logic        GMII_TXER,
    output logic [15:0] frame_cnt0,
    output logic [15:0] frame_cnt1,
    output logic [7:0]  timeout_cnt
);

    localparam int TMO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int IPG_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);
    localparam logic [IPG_W-1:0] IPG_LAST = IPG_W'(IPG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_PASS  = 2'd2,
        S_IPG   = 2'd3
    } state_t;

    state_t           state_q;
    logic             sel_q;    // currently selected source
    logic             last_q;   // last-served source
    logic [TMO_W-1:0] tmo_q;
    logic [IPG_W-1:0] ipg_q;
    logic             gnt0_q, gnt1_q;
    logic [7:0]       txd_q;
    logic             txen_q, txer_q;
    logic [15:0]      fcnt0_q, fcnt1_q;
    logic [7:0]       tcnt_q;

    // Selected-source view; the other source is never looked at.
    logic       req_s, txen_s, txer_s;
    logic [7:0] txd_s;
    logic       pick_d;  // winner when arbitrating in IDLE
    logic       fwd_d;   // outputs follow the selected source this cycle

    always_comb begin
        req_s  = sel_q ? req1  : req0;
        txen_s = sel_q ? txen1 : txen0;
        txer_s = sel_q ? txer1 : txer0;
        txd_s  = sel_q ? txd1  : txd0;
        // Contention goes to whoever was not served last.
        pick_d = (req0 && req1) ? ~last_q : req1;
        fwd_d  = (state_q == S_GRANT) || (state_q == S_PASS);
    end

    always_ff @(posedge GMII_GTXCLK) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            tmo_q   <= '0;
            ipg_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            txd_q   <= 8'h00;
            txen_q  <= 1'b0;
            txer_q  <= 1'b0;
            fcnt0_q <= 16'h0000;
            fcnt1_q <= 16'h0000;
            tcnt_q  <= 8'h00;
        end else begin
            txd_q  <= fwd_d ? txd_s  : 8'h00;
            txen_q <= fwd_d ? txen_s : 1'b0;
            txer_q <= fwd_d ? txer_s : 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        sel_q   <= pick_d;
                        gnt0_q  <= ~pick_d;
                        gnt1_q  <= pick_d;
                        tmo_q   <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (txen_s) begin
                        state_q <= S_PASS;
                    end else if (!req_s) begin
                        // Source withdrew before starting: no gap, no count.
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        last_q  <= sel_q;
                        state_q <= S_IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        last_q  <= sel_q;
                        ipg_q   <= '0;
                        if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
                        state_q <= S_IPG;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_PASS: begin
                    // Frame ends on the first sampled txen low; req is ignored.
                    if (!txen_s) begin
                        gnt0_q <= 1'b0;
                        gnt1_q <= 1'b0;
                        last_q <= sel_q;
                        ipg_q  <= '0;
                        if (sel_q) fcnt1_q <= fcnt1_q + 16'd1;
                        else       fcnt0_q <= fcnt0_q + 16'd1;
                        state_q <= S_IPG;
                    end
                end
                S_IPG: begin
                    ipg_q <= ipg_q + 1'b1;
                    if (ipg_q == IPG_LAST) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign GMII_TXD    = txd_q;
    assign GMII_TXEN   = txen_q;
    assign GMII_TXER   = txer_q;
    assign frame_cnt0  = fcnt0_q;
    assign frame_cnt1  = fcnt1_q;
    assign timeout_cnt = tcnt_q;

endmodule
